peripheral_uart_fifo: RTL and testbench
=======================================

Name: peripheral_uart_fifo

Overview:
Memory-mapped UART peripheral for the stopwatch SoC bus (cs/addr/rd/wr, 32-bit data). It extends the single-byte UART with parametrised TX and RX FIFOs, a runtime baud divisor, optional even parity, and sticky error flags. It also provides an internal loopback mode for self-test. The CPU sees one register file. Serial pins connect straight to the board.

Parameters:
CLK_FREQ, 25000000, system clock in Hz; used only for the divisor reset value.
BAUD, 115200, reset baud rate; DIV resets to CLK_FREQ/BAUD (integer division).
FIFO_DEPTH, 16, entries per FIFO. Must be a power of 2 and at least 2.

Ports:
clk  in  1  system clock; all logic is rising-edge.
rst  in  1  reset, synchronous and active-low: sampled on clk rising edge, 0 = reset.
d_in  in  32  write data.
cs  in  1  chip select; rd and wr are ignored unless cs=1.
addr  in  5  byte register address.
rd  in  1  read strobe.
wr  in  1  write strobe.
d_out  out  32  registered read data.
uart_tx  out  1  serial out, idle high.
uart_rx  in  1  serial in, idle high, asynchronous to clk.
ledout  out  1  equals ~rx_empty; lit while RX data is pending.

Behaviour:
- Reset state: d_out=0, uart_tx=1, ledout=0. FIFOs empty. Flags cleared. CTRL=0. DIV=CLK_FREQ/BAUD. TX and RX engines idle. Reset asserted mid-frame forces uart_tx=1 on that same edge.
- Register map (unused bits read 0; unmapped addresses read 0 and ignore writes):
  - 0x00 STATUS (R, W1C):
    - b0 tx_full, b1 tx_empty, b2 rx_empty, b3 rx_full, b6 tx_busy.
    - Sticky: b4 rx_overrun, b5 parity_err, b7 frame_err.
    - Writing 1 to b4/b5/b7 clears that bit.
  - 0x04 TXDATA (W): pushes d_in[7:0] into the TX FIFO. The write is dropped if the FIFO is full, unless the TX engine pops in the same cycle.
  - 0x08 RXDATA (R): d_out[7:0] = FIFO head, and the FIFO pops. When empty, returns 0 and does not pop.
  - 0x0C CTRL (RW): b0 tx_en, b1 rx_en, b2 parity_en, b3 loopback.
  - 0x10 DIV (RW): [15:0] clocks per bit. Writes below 4 are stored as 4.
  - 0x14 LEVEL (R): [7:0] TX count, [15:8] RX count.
- Read timing: when cs&rd, d_out is updated on the next edge (1-cycle latency). Otherwise d_out holds its value.
- Bus conflicts: if cs&rd&wr, only the write acts and d_out holds.
- TX engine: IDLE → START → DATA(8, LSB first) → PARITY (only if parity_en) → STOP → IDLE.
  - Leaves IDLE when tx_en=1 and the TX FIFO is non-empty: pops the FIFO and drives the start bit on the next edge.
  - Each bit lasts DIV clocks; DIV is latched at frame start.
  - Parity is even: XOR of the 8 data bits.
  - Clearing tx_en mid-frame finishes the current frame, then the engine stops.
  - tx_busy = 1 whenever the engine is not in IDLE.
- RX engine:
  - Input path: uart_rx (or uart_tx when loopback=1; uart_rx is then ignored) passes through a 2-flop synchronizer.
  - Start: in IDLE with rx_en=1, a high-to-low edge starts a wait of DIV/2 clocks. If the line is high at that point it is a false start and the engine returns to IDLE. Otherwise sampling begins, one sample every DIV clocks: 8 data bits, then parity if enabled, then stop.
  - Stop sampled 0: set frame_err and discard the byte.
  - Parity mismatch: set parity_err; the byte is still pushed.
  - Push into a full RX FIFO: set rx_overrun and drop the byte, unless a CPU pop occurs in the same cycle, in which case the push is accepted.
- FIFOs: circular buffers with log2(FIFO_DEPTH)+1-bit pointers. Pointers wrap modulo depth. A simultaneous push and pop leaves the count unchanged.
- Runtime writes: CTRL and DIV may change at any time. The new values take effect at the next frame.

Test Plan:
- Reset: hold rst=0 for 2 edges, release → d_out=0, uart_tx=1, ledout=0; STATUS reads 0x06; DIV reads CLK_FREQ/BAUD=217.
- Loopback: write DIV=8, CTRL=0x0B, TXDATA=0x55 → uart_tx frame 0,1,0,1,0,1,0,1,0,1 at 8 clocks/bit. Then ledout=1, and an RXDATA read returns 0x55 with STATUS b2=1 afterwards.
- Parity: CTRL=0x0F, TXDATA=0xA5 → 11-bit frame with parity bit 0. Externally drive 0xA5 with parity bit 1 → STATUS b5=1, RXDATA=0xA5. Write STATUS=0x20 → b5=0.
- TX full: tx_en=0, write 17 bytes 0x00..0x10 → LEVEL[7:0]=16, STATUS b0=1, 0x10 dropped. Set tx_en → 16 frames sent, in order 0x00..0x0F.
- RX overrun and frame error: loopback, send 17 bytes without reading → STATUS b3=1 and b4=1; reads return the first 16 bytes intact. Externally drive a frame with stop=0 → b7=1, RX count unchanged.
- Reset mid-frame: assert rst during the 4th data bit → uart_tx=1 on that edge; STATUS=0x06 and LEVEL=0 after release.

Source files
------------

// File: rtl/peripheral_uart_fifo.sv
// Purpose: memory-mapped UART with TX/RX FIFOs, runtime divisor, even parity, loopback.
// Latency: register reads appear on d_out one clock after cs&rd; TX start bit one clock after pop.
// Backpressure: full TX FIFO drops CPU writes; full RX FIFO drops received bytes and flags overrun.

module uart_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [W-1:0]              push_dat,
    input  logic                      pop,
    output logic                      push_acc,
    output logic [W-1:0]              head_dat,
    output logic                      empty,
    output logic                      full,
    output logic [$clog2(DEPTH):0]    count
);
    // Circular buffer, extra pointer bit separates full from empty.
    // Latency: pushed data visible at head one clock later.
    // Backpressure: push into full buffer is refused unless a pop happens the same cycle.
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         pop_ok;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count    = wr_ptr - rd_ptr;
    assign head_dat = mem[rd_ptr[AW-1:0]];
    assign pop_ok   = pop && !empty;
    assign push_acc = push && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)   rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc) mem[wr_ptr[AW-1:0]] <= push_dat;
    end
endmodule

module peripheral_uart_fifo #(
    parameter int CLK_FREQ   = 25000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] d_in,
    input  logic        cs,
    input  logic [4:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [31:0] d_out,
    output logic        uart_tx,
    input  logic        uart_rx,
    output logic        ledout
);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int DIV_RST = CLK_FREQ / BAUD;

    localparam logic [4:0] A_STATUS = 5'h00;
    localparam logic [4:0] A_TXDATA = 5'h04;
    localparam logic [4:0] A_RXDATA = 5'h08;
    localparam logic [4:0] A_CTRL   = 5'h0C;
    localparam logic [4:0] A_DIV    = 5'h10;
    localparam logic [4:0] A_LEVEL  = 5'h14;

    typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PARITY, T_STOP} tx_state_t;
    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PARITY, R_STOP} rx_state_t;

    logic        wr_en, rd_en;
    logic [3:0]  ctrl;
    logic [15:0] div;
    logic        rx_overrun, parity_err, frame_err;
    logic [31:0] rdata;
    logic        unused_bits;

    logic        tx_empty, tx_full, tx_pop, tx_push_acc;
    logic [7:0]  tx_head;
    logic [AW:0] tx_count;
    logic        rx_empty, rx_full, rx_pop, rx_push, rx_push_acc;
    logic [7:0]  rx_head;
    logic [AW:0] rx_count;

    assign wr_en       = cs && wr;
    assign rd_en       = cs && rd && !wr;
    assign rx_pop      = rd_en && (addr == A_RXDATA);
    assign unused_bits = ^d_in[31:16];

    uart_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (wr_en && (addr == A_TXDATA)),
        .push_dat (d_in[7:0]),
        .pop      (tx_pop),
        .push_acc (tx_push_acc),
        .head_dat (tx_head),
        .empty    (tx_empty),
        .full     (tx_full),
        .count    (tx_count)
    );

    // ---------------- TX engine ----------------
    tx_state_t   tx_state, tx_state_nxt;
    logic [15:0] tx_div, tx_cnt;
    logic [7:0]  tx_sh;
    logic [2:0]  tx_bit;
    logic        tx_par_en, tx_par, tx_q, tx_bit_end;

    assign tx_bit_end = (tx_cnt == tx_div - 16'd1);
    assign uart_tx    = tx_q;

    always_comb begin
        tx_state_nxt = tx_state;
        tx_pop       = 1'b0;
        case (tx_state)
            T_IDLE: begin
                if (ctrl[0] && !tx_empty) begin
                    tx_pop       = 1'b1;
                    tx_state_nxt = T_START;
                end
            end
            T_START:  if (tx_bit_end) tx_state_nxt = T_DATA;
            T_DATA:   if (tx_bit_end && tx_bit == 3'd7) tx_state_nxt = tx_par_en ? T_PARITY : T_STOP;
            T_PARITY: if (tx_bit_end) tx_state_nxt = T_STOP;
            T_STOP:   if (tx_bit_end) tx_state_nxt = T_IDLE;
            default:  tx_state_nxt = T_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_state  <= T_IDLE;
            tx_q      <= 1'b1;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_sh     <= '0;
            tx_div    <= 16'd4;
            tx_par_en <= 1'b0;
            tx_par    <= 1'b0;
        end else begin
            tx_state <= tx_state_nxt;
            if (tx_state == T_IDLE) begin
                tx_cnt <= '0;
                tx_bit <= '0;
                if (tx_pop) begin
                    tx_sh     <= tx_head;
                    tx_par    <= ^tx_head;
                    tx_div    <= div;
                    tx_par_en <= ctrl[2];
                    tx_q      <= 1'b0;
                end
            end else if (tx_bit_end) begin
                tx_cnt <= '0;
                case (tx_state)
                    T_START: tx_q <= tx_sh[0];
                    T_DATA: begin
                        tx_bit <= tx_bit + 3'd1;
                        tx_sh  <= {1'b0, tx_sh[7:1]};
                        if (tx_bit == 3'd7) tx_q <= tx_par_en ? tx_par : 1'b1;
                        else                tx_q <= tx_sh[1];
                    end
                    default: tx_q <= 1'b1;
                endcase
            end else begin
                tx_cnt <= tx_cnt + 16'd1;
            end
        end
    end

    // ---------------- RX engine ----------------
    rx_state_t   rx_state, rx_state_nxt;
    logic        rx_s1, rx_s2, rx_s3, rx_fall;
    logic [15:0] rx_div, rx_cnt;
    logic [7:0]  rx_sh;
    logic [2:0]  rx_bit;
    logic        rx_par_en, rx_half_end, rx_bit_end, rx_par_set, rx_frame_set;

    assign rx_fall     = rx_s3 && !rx_s2;
    assign rx_half_end = (rx_cnt == {1'b0, rx_div[15:1]} - 16'd1);
    assign rx_bit_end  = (rx_cnt == rx_div - 16'd1);

    always_comb begin
        rx_state_nxt = rx_state;
        rx_push      = 1'b0;
        rx_par_set   = 1'b0;
        rx_frame_set = 1'b0;
        case (rx_state)
            R_IDLE:  if (ctrl[1] && rx_fall) rx_state_nxt = R_START;
            R_START: if (rx_half_end) rx_state_nxt = rx_s2 ? R_IDLE : R_DATA;
            R_DATA:  if (rx_bit_end && rx_bit == 3'd7) rx_state_nxt = rx_par_en ? R_PARITY : R_STOP;
            R_PARITY: begin
                if (rx_bit_end) begin
                    rx_state_nxt = R_STOP;
                    rx_par_set   = (rx_s2 != ^rx_sh);
                end
            end
            R_STOP: begin
                if (rx_bit_end) begin
                    rx_state_nxt = R_IDLE;
                    rx_push      = rx_s2;
                    rx_frame_set = !rx_s2;
                end
            end
            default: rx_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            rx_s3     <= 1'b1;
            rx_state  <= R_IDLE;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_sh     <= '0;
            rx_div    <= 16'd4;
            rx_par_en <= 1'b0;
        end else begin
            rx_s1    <= ctrl[3] ? tx_q : uart_rx;
            rx_s2    <= rx_s1;
            rx_s3    <= rx_s2;
            rx_state <= rx_state_nxt;
            // Divisor and parity mode tracked while idle, frozen for the frame.
            if (rx_state == R_IDLE) begin
                rx_cnt    <= '0;
                rx_bit    <= '0;
                rx_div    <= div;
                rx_par_en <= ctrl[2];
            end else if ((rx_state == R_START) ? rx_half_end : rx_bit_end) begin
                rx_cnt <= '0;
                if (rx_state == R_DATA) begin
                    rx_sh  <= {rx_s2, rx_sh[7:1]};
                    rx_bit <= rx_bit + 3'd1;
                end
            end else begin
                rx_cnt <= rx_cnt + 16'd1;
            end
        end
    end

    uart_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (rx_push),
        .push_dat (rx_sh),
        .pop      (rx_pop),
        .push_acc (rx_push_acc),
        .head_dat (rx_head),
        .empty    (rx_empty),
        .full     (rx_full),
        .count    (rx_count)
    );

    assign ledout = !rx_empty;

    // ---------------- register file ----------------
    always_comb begin
        rdata = '0;
        case (addr)
            A_STATUS: rdata = {24'b0, frame_err, (tx_state != T_IDLE), parity_err, rx_overrun,
                               rx_full, rx_empty, tx_empty, tx_full};
            A_RXDATA: rdata = rx_empty ? 32'b0 : {24'b0, rx_head};
            A_CTRL:   rdata = {28'b0, ctrl};
            A_DIV:    rdata = {16'b0, div};
            A_LEVEL:  rdata = {16'b0, 8'(rx_count), 8'(tx_count)};
            default:  rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ctrl       <= '0;
            div        <= 16'(DIV_RST);
            rx_overrun <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            d_out      <= '0;
        end else begin
            if (wr_en && addr == A_CTRL) ctrl <= d_in[3:0];
            if (wr_en && addr == A_DIV)  div  <= (d_in[15:0] < 16'd4) ? 16'd4 : d_in[15:0];
            if (wr_en && addr == A_STATUS) begin
                if (d_in[4]) rx_overrun <= 1'b0;
                if (d_in[5]) parity_err <= 1'b0;
                if (d_in[7]) frame_err  <= 1'b0;
            end
            // A flag event in the same cycle as its clear wins.
            if (rx_push && !rx_push_acc) rx_overrun <= 1'b1;
            if (rx_par_set)              parity_err <= 1'b1;
            if (rx_frame_set)            frame_err  <= 1'b1;
            if (rd_en)                   d_out      <= rdata;
        end
    end
endmodule

// File: tb/tb_peripheral_uart_fifo.sv
// Directed bench for peripheral_uart_fifo: register vector table plus serial frame sequences.
module tb_peripheral_uart_fifo;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] d_in = '0;
    logic        cs = 1'b0;
    logic [4:0]  addr = '0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] d_out;
    logic        uart_tx;
    logic        uart_rx = 1'b1;
    logic        ledout;

    int total = 0;
    int bad   = 0;

    peripheral_uart_fifo dut (
        .clk     (clk),
        .rst     (rst),
        .d_in    (d_in),
        .cs      (cs),
        .addr    (addr),
        .rd      (rd),
        .wr      (wr),
        .d_out   (d_out),
        .uart_tx (uart_tx),
        .uart_rx (uart_rx),
        .ledout  (ledout)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_wr;
        logic [4:0]  a;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 19;
    vec_t vt [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] v);
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; addr = a; d_in = v;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0; d_in = '0;
    endtask

    task automatic reg_read(input logic [4:0] a, output logic [31:0] v);
        @(negedge clk);
        cs = 1'b1; rd = 1'b1; addr = a;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
        v = d_out;
    endtask

    task automatic read_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] v;
        reg_read(a, v);
        chk(name, v, exp);
    endtask

    // Samples bit centres of one frame at 8 clocks per bit; bit i of fr is the i-th bit on the wire.
    task automatic get_frame(input int nbits, output logic [10:0] fr, output bit ok);
        int t;
        t  = 0;
        fr = '0;
        ok = 1'b0;
        while (uart_tx !== 1'b0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t < 3000) begin
            repeat (4) @(negedge clk);
            for (int i = 0; i < nbits; i++) begin
                fr[i] = uart_tx;
                if (i < nbits - 1) repeat (8) @(negedge clk);
            end
            ok = 1'b1;
        end
    endtask

    task automatic frame_chk(input string name, input int nbits, input logic [10:0] exp);
        logic [10:0] fr;
        bit ok;
        get_frame(nbits, fr, ok);
        chk({name, "_seen"}, {31'b0, ok}, 32'd1);
        if (ok) chk(name, {21'b0, fr}, {21'b0, exp});
    endtask

    task automatic send_rx(input logic [7:0] d, input bit par_en, input bit par, input bit stop);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            repeat (8) @(negedge clk);
        end
        if (par_en) begin
            uart_rx = par;
            repeat (8) @(negedge clk);
        end
        uart_rx = stop;
        repeat (8) @(negedge clk);
        uart_rx = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic wait_led(input string name);
        int t;
        t = 0;
        while (ledout !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk(name, {31'b0, ledout}, 32'd1);
    endtask

    initial begin
        logic [31:0] v;
        int t;

        vt[0]  = '{1'b0, 5'h00, 32'h0,        32'h06};
        vt[1]  = '{1'b0, 5'h10, 32'h0,        32'd217};
        vt[2]  = '{1'b0, 5'h0C, 32'h0,        32'h0};
        vt[3]  = '{1'b0, 5'h14, 32'h0,        32'h0};
        vt[4]  = '{1'b0, 5'h08, 32'h0,        32'h0};
        vt[5]  = '{1'b0, 5'h18, 32'h0,        32'h0};
        vt[6]  = '{1'b1, 5'h10, 32'd3,        32'h0};
        vt[7]  = '{1'b0, 5'h10, 32'h0,        32'd4};
        vt[8]  = '{1'b1, 5'h10, 32'h12345,    32'h0};
        vt[9]  = '{1'b0, 5'h10, 32'h0,        32'h2345};
        vt[10] = '{1'b1, 5'h0C, 32'hFF,       32'h0};
        vt[11] = '{1'b0, 5'h0C, 32'h0,        32'h0F};
        vt[12] = '{1'b1, 5'h0C, 32'h0,        32'h0};
        vt[13] = '{1'b1, 5'h1C, 32'hFFFFFFFF, 32'h0};
        vt[14] = '{1'b0, 5'h1C, 32'h0,        32'h0};
        vt[15] = '{1'b1, 5'h00, 32'hFF,       32'h0};
        vt[16] = '{1'b0, 5'h00, 32'h0,        32'h06};
        vt[17] = '{1'b0, 5'h0C, 32'h0,        32'h0};
        vt[18] = '{1'b0, 5'h14, 32'h0,        32'h0};

        // reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        chk("rst_d_out", d_out, 32'h0);
        chk("rst_uart_tx", {31'b0, uart_tx}, 32'd1);
        chk("rst_ledout", {31'b0, ledout}, 32'd0);

        for (int i = 0; i < NV; i++) begin
            if (vt[i].is_wr) bus_write(vt[i].a, vt[i].wd);
            else begin
                reg_read(vt[i].a, v);
                chk($sformatf("vec%0d", i), v, vt[i].exp);
            end
        end

        // read+write conflict: write acts, d_out holds
        reg_read(5'h10, v);
        @(negedge clk);
        cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = 5'h0C; d_in = 32'h5;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0; wr = 1'b0; d_in = '0;
        chk("conflict_hold", d_out, 32'h2345);
        read_chk("conflict_wr", 5'h0C, 32'h5);
        bus_write(5'h0C, 32'h0);

        // loopback 0x55
        bus_write(5'h10, 32'd8);
        bus_write(5'h0C, 32'h0B);
        bus_write(5'h04, 32'h55);
        frame_chk("lb_frame", 10, {1'b0, 1'b1, 8'h55, 1'b0});
        wait_led("lb_led");
        repeat (16) @(negedge clk);
        read_chk("lb_rxdata", 5'h08, 32'h55);
        read_chk("lb_status", 5'h00, 32'h06);
        chk("lb_led_off", {31'b0, ledout}, 32'd0);

        // parity
        bus_write(5'h0C, 32'h0F);
        bus_write(5'h04, 32'hA5);
        frame_chk("par_frame", 11, {1'b1, 1'b0, 8'hA5, 1'b0});
        wait_led("par_led");
        repeat (16) @(negedge clk);
        read_chk("par_lb_rx", 5'h08, 32'hA5);
        read_chk("par_lb_status", 5'h00, 32'h06);
        bus_write(5'h0C, 32'h06);
        send_rx(8'hA5, 1'b1, 1'b1, 1'b1);
        wait_led("par_ext_led");
        read_chk("par_err_status", 5'h00, 32'h22);
        read_chk("par_err_rx", 5'h08, 32'hA5);
        bus_write(5'h00, 32'h20);
        read_chk("par_clr", 5'h00, 32'h06);

        // TX full
        bus_write(5'h0C, 32'h00);
        for (int i = 0; i < 17; i++) bus_write(5'h04, i);
        read_chk("txfull_level", 5'h14, 32'h10);
        read_chk("txfull_status", 5'h00, 32'h05);
        bus_write(5'h0C, 32'h01);
        for (int i = 0; i < 16; i++)
            frame_chk($sformatf("txfull_frame%0d", i), 10, {1'b0, 1'b1, 8'(i), 1'b0});
        repeat (40) @(negedge clk);
        read_chk("txfull_drained", 5'h14, 32'h0);
        read_chk("txfull_idle", 5'h00, 32'h06);

        // RX overrun via loopback
        bus_write(5'h0C, 32'h0B);
        for (int i = 0; i < 17; i++) bus_write(5'h04, 32'h20 + i);
        repeat (17 * 80 + 300) @(negedge clk);
        read_chk("ovr_status", 5'h00, 32'h1A);
        read_chk("ovr_level", 5'h14, 32'h1000);
        for (int i = 0; i < 16; i++)
            read_chk($sformatf("ovr_rx%0d", i), 5'h08, 32'h20 + i);
        read_chk("ovr_after", 5'h00, 32'h16);
        bus_write(5'h00, 32'h10);
        read_chk("ovr_clr", 5'h00, 32'h06);

        // frame error
        bus_write(5'h0C, 32'h02);
        send_rx(8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        read_chk("ferr_status", 5'h00, 32'h86);
        read_chk("ferr_level", 5'h14, 32'h0);

        // reset mid-frame during data bit 3
        bus_write(5'h0C, 32'h01);
        bus_write(5'h04, 32'h00);
        bus_write(5'h04, 32'h00);
        t = 0;
        while (uart_tx !== 1'b0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("mid_start_seen", {31'b0, uart_tx}, 32'd0);
        repeat (36) @(negedge clk);
        chk("mid_pre_tx", {31'b0, uart_tx}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_tx", {31'b0, uart_tx}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        chk("mid_d_out", d_out, 32'h0);
        read_chk("mid_status", 5'h00, 32'h06);
        read_chk("mid_level", 5'h14, 32'h0);
        read_chk("mid_div", 5'h10, 32'd217);
        read_chk("mid_ctrl", 5'h0C, 32'h0);
        chk("mid_ledout", {31'b0, ledout}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
